ahb_mtx_slv_sched: RTL and testbench

- Per-slave-port transfer scheduler for the AHB-Lite matrix. It shares one slave port between MST_NUM masters.
- It chooses the address-phase owner by fixed priority, with round-robin among masters at the same priority.
- It holds ownership for the whole burst and for locked sequences, and tracks which master owns the data phase.
- Its one-hot outputs drive the slave-port address mux and the response/read-data demux.

---
 rtl/ahb_mtx_slv_sched_if.sv | 28 ++
 rtl/ahb_mtx_slv_sched.sv | 151 +++++++++++++++
 tb/tb_ahb_mtx_slv_sched.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_mtx_slv_sched_if.sv
// Bus bundle between the masters of one AHB-Lite matrix slave port and its
// transfer scheduler. The master side drives the request/burst qualifiers and
// HREADYOUT. The slave side (the scheduler) returns the address and data owner selects.
interface ahb_mtx_slv_sched_if #(
  parameter int MST_NUM   = 3,
  parameter int PRI_WIDTH = 2
);
  logic [MST_NUM-1:0]           req;
  logic [PRI_WIDTH*MST_NUM-1:0] pri;
  logic [3*MST_NUM-1:0]         hburst;
  logic [MST_NUM-1:0]           hmastlock;
  logic                         hready;
  logic [MST_NUM-1:0]           addr_sel;
  logic                         addr_vld;
  logic [MST_NUM-1:0]           data_sel;
  logic                         data_vld;
  logic                         locked;

  modport master (
    output req, pri, hburst, hmastlock, hready,
    input  addr_sel, addr_vld, data_sel, data_vld, locked
  );

  modport slave (
    input  req, pri, hburst, hmastlock, hready,
    output addr_sel, addr_vld, data_sel, data_vld, locked
  );
endinterface

// File: rtl/ahb_mtx_slv_sched.sv
// Per-slave-port scheduler: fixed-priority arbitration with round-robin among
// equal priorities. Ownership is held for a whole burst or locked sequence.
// The data-phase owner is tracked for the response/read-data demux.
module ahb_mtx_slv_sched #(
  parameter int MST_NUM   = 3,
  parameter int PRI_WIDTH = 2,
  parameter int MAX_HOLD  = 16
) (
  input logic               clk,
  input logic               rst,
  ahb_mtx_slv_sched_if.slave bus
);
  localparam int IDX_W     = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;
  localparam int MAX_BEATS = (MAX_HOLD > 16) ? MAX_HOLD : 16;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [MST_NUM-1:0] SEL0 = MST_NUM'(1);

  typedef enum logic {ARB, OWN} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [MST_NUM-1:0]   addr_sel_q, addr_sel_d;
  logic [MST_NUM-1:0]   data_sel_q, data_sel_d;
  logic                 addr_vld_q, addr_vld_d;
  logic                 data_vld_q, data_vld_d;
  logic                 locked_q, locked_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [PRI_WIDTH-1:0] max_pri;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;

  // INCR has no defined length, so it is capped at MAX_HOLD beats.
  function automatic logic [CNT_W-1:0] burst_beats(input logic [2:0] hb);
    case (hb)
      3'b000:         return CNT_W'(1);
      3'b001:         return CNT_W'(MAX_HOLD);
      3'b010, 3'b011: return CNT_W'(4);
      3'b100, 3'b101: return CNT_W'(8);
      default:        return CNT_W'(16);
    endcase
  endfunction

  // Arbitration: highest requesting priority, then first match after the pointer.
  always_comb begin
    max_pri   = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < MST_NUM; i++) begin
      if (bus.req[i] && (bus.pri[i*PRI_WIDTH +: PRI_WIDTH] > max_pri))
        max_pri = bus.pri[i*PRI_WIDTH +: PRI_WIDTH];
    end
    for (int k = 1; k <= MST_NUM; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % MST_NUM;
      if (!win_found && bus.req[idx] &&
          (bus.pri[idx*PRI_WIDTH +: PRI_WIDTH] == max_pri)) begin
        win_idx   = IDX_W'(idx);
        win_found = 1'b1;
      end
    end
  end

  // Next-state: grant in ARB; in OWN count accepted beats and release on
  // the last unlocked beat or on an unlocked owner that dropped its request.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    addr_sel_d = addr_sel_q;
    data_sel_d = data_sel_q;
    addr_vld_d = addr_vld_q;
    data_vld_d = data_vld_q;
    locked_d   = locked_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB: begin
        if (|bus.req) begin
          owner_d    = win_idx;
          addr_sel_d = SEL0 << win_idx;
          addr_vld_d = 1'b1;
          beat_cnt_d = burst_beats(bus.hburst[win_idx*3 +: 3]);
          locked_d   = bus.hmastlock[win_idx];
          state_d    = OWN;
        end else begin
          addr_vld_d = 1'b0;
        end
        if (bus.hready) data_vld_d = 1'b0;
      end
      OWN: begin
        if (bus.hready) begin
          if (bus.req[owner_q]) begin
            data_sel_d = addr_sel_q;
            data_vld_d = 1'b1;
            locked_d   = bus.hmastlock[owner_q];
            if (beat_cnt_q == CNT_W'(1)) begin
              if (bus.hmastlock[owner_q]) begin
                beat_cnt_d = burst_beats(bus.hburst[owner_q*3 +: 3]);
              end else begin
                state_d    = ARB;
                addr_vld_d = 1'b0;
                ptr_d      = owner_q;
              end
            end else begin
              beat_cnt_d = beat_cnt_q - CNT_W'(1);
            end
          end else begin
            data_vld_d = 1'b0;
            if (!locked_q) begin
              state_d    = ARB;
              addr_vld_d = 1'b0;
              ptr_d      = owner_q;
            end
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State register; reset parks master 0 and makes it first in round-robin order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      owner_q    <= '0;
      ptr_q      <= IDX_W'(MST_NUM - 1);
      addr_sel_q <= SEL0;
      data_sel_q <= '0;
      addr_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      locked_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      addr_sel_q <= addr_sel_d;
      data_sel_q <= data_sel_d;
      addr_vld_q <= addr_vld_d;
      data_vld_q <= data_vld_d;
      locked_q   <= locked_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.addr_sel = addr_sel_q;
  assign bus.addr_vld = addr_vld_q;
  assign bus.data_sel = data_sel_q;
  assign bus.data_vld = data_vld_q;
  assign bus.locked   = locked_q;
endmodule

// File: tb/tb_ahb_mtx_slv_sched.sv
// Bench for ahb_mtx_slv_sched: directed scenarios followed by random traffic.
// Every cycle is compared against a transaction-level reference model.
module tb_ahb_mtx_slv_sched;
  localparam int M  = 3;
  localparam int PW = 2;
  localparam int MH = 16;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ahb_mtx_slv_sched_if #(.MST_NUM(M), .PRI_WIDTH(PW)) bus ();

  ahb_mtx_slv_sched #(.MST_NUM(M), .PRI_WIDTH(PW), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: who owns the port, how many beats remain, etc.
  bit m_own;
  int m_owner, m_ptr, m_dsel, m_beats;
  bit m_avld, m_dvld, m_lock;
  int bt[8] = '{1, MH, 4, 4, 8, 8, 16, 16};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rank each requester by (priority, closeness after the pointer).
  // The highest key wins.
  function automatic int pick(input logic [M-1:0] r, input logic [PW*M-1:0] p, input int ptr);
    int best = 0;
    int bkey = -1;
    for (int i = 0; i < M; i++) begin
      if (r[i]) begin
        int d, key;
        d   = (i - ptr - 1 + 2 * M) % M;
        key = int'(p[i*PW +: PW]) * M + (M - 1 - d);
        if (key > bkey) begin
          bkey = key;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model(input logic [M-1:0] r, input logic [PW*M-1:0] p,
                       input logic [3*M-1:0] hb, input logic [M-1:0] hl,
                       input logic hr, input logic rs);
    if (rs) begin
      m_own = 0; m_owner = 0; m_ptr = M - 1; m_avld = 0;
      m_dsel = -1; m_dvld = 0; m_lock = 0; m_beats = 0;
    end else if (!m_own) begin
      if (r != '0) begin
        int w;
        w       = pick(r, p, m_ptr);
        m_owner = w;
        m_avld  = 1;
        m_beats = bt[hb[3*w +: 3]];
        m_lock  = hl[w];
        m_own   = 1;
      end else begin
        m_avld = 0;
      end
      if (hr) m_dvld = 0;
    end else if (hr) begin
      if (r[m_owner]) begin
        m_dsel = m_owner;
        m_dvld = 1;
        m_lock = hl[m_owner];
        if (m_beats == 1) begin
          if (hl[m_owner]) m_beats = bt[hb[3*m_owner +: 3]];
          else begin
            m_own = 0; m_avld = 0; m_ptr = m_owner;
          end
        end else begin
          m_beats--;
        end
      end else begin
        m_dvld = 0;
        if (!m_lock) begin
          m_own = 0; m_avld = 0; m_ptr = m_owner;
        end
      end
    end
  endtask

  // One clock: capture inputs, advance the model at the edge, compare 1 ns later.
  task automatic step();
    logic [M-1:0]    r, hl;
    logic [PW*M-1:0] p;
    logic [3*M-1:0]  hb;
    logic            hr, rs;
    logic [M-1:0]    exp_dsel;
    r = bus.req; p = bus.pri; hb = bus.hburst; hl = bus.hmastlock;
    hr = bus.hready; rs = rst;
    @(posedge clk);
    model(r, p, hb, hl, hr, rs);
    #1;
    exp_dsel = (m_dsel < 0) ? '0 : M'(1) << m_dsel;
    check("m_addr_sel", 32'(bus.addr_sel), 32'(M'(1) << m_owner));
    check("m_addr_vld", 32'(bus.addr_vld), 32'(m_avld));
    check("m_data_sel", 32'(bus.data_sel), 32'(exp_dsel));
    check("m_data_vld", 32'(bus.data_vld), 32'(m_dvld));
    check("m_locked",   32'(bus.locked),   32'(m_lock));
    check("inv_asel_onehot", 32'($onehot(bus.addr_sel)), 32'd1);
    if (bus.data_vld) check("inv_dsel_onehot", 32'($onehot(bus.data_sel)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req = '0; bus.pri = '0; bus.hburst = '0; bus.hmastlock = '0; bus.hready = 1'b1;
    rst = 1'b1;

    // Test 1: single master, SINGLE transfer
    do_reset();
    check("rst_addr_sel", 32'(bus.addr_sel), 32'h1);
    check("rst_addr_vld", 32'(bus.addr_vld), 32'h0);
    check("rst_data_sel", 32'(bus.data_sel), 32'h0);
    check("rst_data_vld", 32'(bus.data_vld), 32'h0);
    check("rst_locked",   32'(bus.locked),   32'h0);
    bus.req = 3'b001;
    step();
    check("t1_grant_sel", 32'(bus.addr_sel), 32'h1);
    check("t1_grant_vld", 32'(bus.addr_vld), 32'h1);
    step();
    check("t1_data_sel", 32'(bus.data_sel), 32'h1);
    check("t1_data_vld", 32'(bus.data_vld), 32'h1);
    check("t1_addr_vld", 32'(bus.addr_vld), 32'h0);
    bus.req = '0;
    step();

    // Test 2: equal priorities rotate with one dead cycle
    do_reset();
    bus.req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      int e;
      e = g % M;
      step();
      check("t2_grant_sel", 32'(bus.addr_sel), 32'(1 << e));
      check("t2_grant_vld", 32'(bus.addr_vld), 32'h1);
      step();
      check("t2_dead_vld", 32'(bus.addr_vld), 32'h0);
      check("t2_data_sel", 32'(bus.data_sel), 32'(1 << e));
    end
    bus.req = '0;
    step();

    // Test 3: INCR4 held against a higher-priority newcomer
    bus.req = 3'b010; bus.hburst = 9'b000_011_000; bus.pri = '0;
    step();
    check("t3_grant_sel", 32'(bus.addr_sel), 32'h2);
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin
        bus.req = 3'b110; bus.pri = 6'b11_00_00;
      end
      step();
      if (k < 4) begin
        check("t3_hold_sel", 32'(bus.addr_sel), 32'h2);
        check("t3_hold_vld", 32'(bus.addr_vld), 32'h1);
      end else begin
        check("t3_release_vld", 32'(bus.addr_vld), 32'h0);
      end
      check("t3_data_sel", 32'(bus.data_sel), 32'h2);
    end
    bus.hburst = '0;
    step();
    check("t3_hi_pri_sel", 32'(bus.addr_sel), 32'h4);
    check("t3_hi_pri_vld", 32'(bus.addr_vld), 32'h1);
    bus.req = '0; bus.pri = '0;
    step();
    step();

    // Test 4: INCR8 with a 3-cycle wait state at beat 5
    do_reset();
    bus.req = 3'b001; bus.hburst = 9'b000_000_101;
    step();
    for (int b = 1; b <= 8; b++) begin
      if (b == 5) begin
        bus.hready = 1'b0;
        for (int w = 0; w < 3; w++) begin
          step();
          check("t4_wait_asel", 32'(bus.addr_sel), 32'h1);
          check("t4_wait_dsel", 32'(bus.data_sel), 32'h1);
          check("t4_wait_avld", 32'(bus.addr_vld), 32'h1);
          check("t4_wait_dvld", 32'(bus.data_vld), 32'h1);
        end
        bus.hready = 1'b1;
      end
      step();
      check("t4_beat_vld", 32'(bus.addr_vld), (b < 8) ? 32'h1 : 32'h0);
    end
    bus.req = '0; bus.hburst = '0;
    step();

    // Test 5: locked sequence survives a request gap
    do_reset();
    bus.req = 3'b011; bus.hmastlock = 3'b001;
    step();
    check("t5_grant_sel", 32'(bus.addr_sel), 32'h1);
    check("t5_grant_lock", 32'(bus.locked), 32'h1);
    step();
    check("t5_first_vld", 32'(bus.addr_vld), 32'h1);
    bus.req = 3'b010;
    for (int g = 0; g < 2; g++) begin
      step();
      check("t5_gap_lock", 32'(bus.locked), 32'h1);
      check("t5_gap_sel",  32'(bus.addr_sel), 32'h1);
      check("t5_gap_vld",  32'(bus.addr_vld), 32'h1);
    end
    bus.req = 3'b011; bus.hmastlock = 3'b000;
    step();
    check("t5_final_vld",  32'(bus.addr_vld), 32'h0);
    check("t5_final_lock", 32'(bus.locked), 32'h0);
    step();
    check("t5_m1_grant", 32'(bus.addr_sel), 32'h2);
    bus.req = '0;
    step();
    step();

    // Test 6: reset in the middle of an INCR16
    do_reset();
    bus.req = 3'b100; bus.hburst = 9'b111_000_000;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_addr_sel", 32'(bus.addr_sel), 32'h1);
    check("t6_addr_vld", 32'(bus.addr_vld), 32'h0);
    check("t6_data_sel", 32'(bus.data_sel), 32'h0);
    check("t6_data_vld", 32'(bus.data_vld), 32'h0);
    check("t6_locked",   32'(bus.locked),   32'h0);
    bus.req = 3'b111; bus.hburst = '0; bus.pri = '0;
    step();
    check("t6_tie_m0", 32'(bus.addr_sel), 32'h1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus.req       = M'($urandom);
      bus.pri       = (PW*M)'($urandom);
      bus.hburst    = (3*M)'($urandom);
      bus.hmastlock = ($urandom_range(0, 7) == 0) ? M'($urandom) : '0;
      bus.hready    = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
